// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single regfile write port.
// Merges the never-stalling ALU result stream with a queued long-latency
// result stream and keeps a pending-destination scoreboard that raises an
// issue stall on RAW/WAW hazards against outstanding long-latency writes.
module wb_arbiter #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    // fixed-latency ALU result stream
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    // long-latency result stream (valid/ready)
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [AW-1:0]            lu_rd,
    input  logic [XLEN-1:0]          lu_data,
    // decode / issue side
    input  logic                     iss_valid,
    input  logic                     iss_long,
    input  logic [AW-1:0]            iss_rd,
    input  logic [AW-1:0]            rs1,
    input  logic [AW-1:0]            rs2,
    output logic                     stall,
    // regfile write port
    output logic                     we,
    output logic [AW-1:0]            wraddr,
    output logic [XLEN-1:0]          wrdata,
    // queue occupancy
    output logic [$clog2(QDEPTH):0]  q_count
);

    localparam int PW   = $clog2(QDEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << AW;

    localparam logic [AW-1:0]   RD_ZERO   = {AW{1'b0}};
    localparam logic [NREG-1:0] REG0_MASK = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_FULL  = CW'(QDEPTH);
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]   PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]    q_rd_q   [QDEPTH];
    logic [XLEN-1:0]  q_data_q [QDEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [NREG-1:0]  pending_q, pending_d;
    logic             we_q,     we_d;
    logic [AW-1:0]    wraddr_q, wraddr_d;
    logic [XLEN-1:0]  wrdata_q, wrdata_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             q_empty;
    logic             push;
    logic             pop;
    logic             alu_take;
    logic [AW-1:0]    head_rd;
    logic [XLEN-1:0]  head_data;
    logic             iss_set;
    logic [NREG-1:0]  clr_vec;
    logic [NREG-1:0]  set_vec;

    // Ready is taken from the registered count only, so a full queue never
    // accepts a push even when it pops in the same cycle.
    assign lu_ready  = !rst && (count_q < CNT_FULL);
    assign push      = lu_valid && lu_ready;
    assign q_empty   = (count_q == {CW{1'b0}});
    assign head_rd   = q_rd_q[rd_ptr_q];
    assign head_data = q_data_q[rd_ptr_q];

    // ALU writes to x0 are bubbles and leave the port to the queue.
    assign alu_take  = alu_valid && (alu_rd != RD_ZERO);
    assign pop       = !alu_take && !q_empty;

    // Hazard stall is built from registered pending bits only.
    assign stall     = iss_valid && (pending_q[rs1] || pending_q[rs2] || pending_q[iss_rd]);
    assign iss_set   = iss_valid && !stall && iss_long && (iss_rd != RD_ZERO);

    // Set wins over clear because the set mask is ORed in last; bit 0 is
    // forced low since x0 never has an outstanding writer.
    assign clr_vec   = pop     ? (REG0_MASK << head_rd) : {NREG{1'b0}};
    assign set_vec   = iss_set ? (REG0_MASK << iss_rd)  : {NREG{1'b0}};
    assign pending_d = ((pending_q & ~clr_vec) | set_vec) & ~REG0_MASK;

    assign we        = we_q;
    assign wraddr    = wraddr_q;
    assign wrdata    = wrdata_q;
    assign q_count   = count_q;

    // Queue pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Fixed-priority write-port selection: ALU first, then queue head.
    always_comb begin
        we_d     = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        if (alu_take) begin
            we_d     = 1'b1;
            wraddr_d = alu_rd;
            wrdata_d = alu_data;
        end else if (pop) begin
            if (head_rd != RD_ZERO) begin
                we_d     = 1'b1;
                wraddr_d = head_rd;
                wrdata_d = head_data;
            end else begin
                we_d     = 1'b0;
                wraddr_d = wraddr_q;
                wrdata_d = wrdata_q;
            end
        end else begin
            we_d     = 1'b0;
            wraddr_d = wraddr_q;
            wrdata_d = wrdata_q;
        end
    end

    // Queue storage: written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_rd_q[i]   <= {AW{1'b0}};
                q_data_q[i] <= {XLEN{1'b0}};
            end
        end else if (push) begin
            q_rd_q[wr_ptr_q]   <= lu_rd;
            q_data_q[wr_ptr_q] <= lu_data;
        end else begin
            q_rd_q[wr_ptr_q]   <= q_rd_q[wr_ptr_q];
            q_data_q[wr_ptr_q] <= q_data_q[wr_ptr_q];
        end
    end

    // Pointers, occupancy and scoreboard; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= {PW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            pending_q <= {NREG{1'b0}};
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Registered regfile write port, one cycle after the selected source.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            wraddr_q <= {AW{1'b0}};
            wrdata_q <= {XLEN{1'b0}};
        end else begin
            we_q     <= we_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a queue-based reference model.
module tb_wb_arbiter;

    localparam int XLEN   = 32;
    localparam int AW     = 5;
    localparam int QDEPTH = 4;
    localparam int CW     = $clog2(QDEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lu_valid;
    logic            lu_ready;
    logic [AW-1:0]   lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            iss_valid;
    logic            iss_long;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            stall;
    logic            we;
    logic [AW-1:0]   wraddr;
    logic [XLEN-1:0] wrdata;
    logic [CW-1:0]   q_count;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .AW(AW), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2), .stall(stall),
        .we(we), .wraddr(wraddr), .wrdata(wrdata), .q_count(q_count)
    );

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    // reference model state
    ent_t            mq[$];
    logic [31:0]     mpend;
    logic            mwe;
    logic [AW-1:0]   mwaddr;
    logic [XLEN-1:0] mwdata;
    logic            maddr_valid;
    logic            mpushed;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lu_valid  = 1'b0; lu_rd  = '0; lu_data  = '0;
        iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    // One clock: compare everything mid-cycle, then advance the model at the edge.
    task automatic step();
        logic exp_ready;
        logic exp_stall;
        ent_t h;
        @(negedge clk);
        exp_ready = !rst && (mq.size() < QDEPTH);
        exp_stall = iss_valid && (mpend[rs1] || mpend[rs2] || mpend[iss_rd]);
        chk("lu_ready", 64'(lu_ready), 64'(exp_ready));
        chk("stall",    64'(stall),    64'(exp_stall));
        chk("we",       64'(we),       64'(mwe));
        chk("q_count",  64'(q_count),  64'(mq.size()));
        if (maddr_valid) begin
            chk("wraddr", 64'(wraddr), 64'(mwaddr));
            chk("wrdata", 64'(wrdata), 64'(mwdata));
        end
        @(posedge clk);
        mpushed = 1'b0;
        if (rst) begin
            mq.delete();
            mpend = 32'd0;
            mwe = 1'b0; mwaddr = '0; mwdata = '0; maddr_valid = 1'b1;
        end else begin
            if (alu_valid && alu_rd != 5'd0) begin
                mwe = 1'b1; mwaddr = alu_rd; mwdata = alu_data; maddr_valid = 1'b1;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                mpend[h.rd] = 1'b0;
                mwe = (h.rd != 5'd0);
                if (mwe) begin
                    mwaddr = h.rd; mwdata = h.data; maddr_valid = 1'b1;
                end else begin
                    maddr_valid = 1'b0;
                end
            end else begin
                mwe = 1'b0; maddr_valid = 1'b0;
            end
            if (exp_ready && lu_valid) begin
                h = {lu_rd, lu_data};
                mq.push_back(h);
                mpushed = 1'b1;
            end
            if (iss_valid && !exp_stall && iss_long && iss_rd != 5'd0) mpend[iss_rd] = 1'b1;
            mpend[0] = 1'b0;
        end
        #1;
    endtask

    initial begin
        int idx;
        logic [AW-1:0]   lrd [5];
        logic [XLEN-1:0] ldat[5];

        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        mq.delete(); mpend = 32'd0; mwe = 1'b0; mwaddr = '0; mwdata = '0;
        maddr_valid = 1'b1; mpushed = 1'b0;

        // reset state
        step(); step();
        rst = 1'b0;
        step();

        // single ALU write, one-cycle latency
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_we_lit",   64'(we),     64'd1);
        chk("alu_addr_lit", 64'(wraddr), 64'd5);
        chk("alu_data_lit", 64'(wrdata), 64'hDEADBEEF);
        idle();
        step();
        chk("alu_we_off_lit", 64'(we), 64'd0);

        // long-latency RAW hazard on x7
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
        step();
        iss_long = 1'b0; iss_rd = 5'd1; rs1 = 5'd7;
        step();
        chk("raw_stall_lit", 64'(stall), 64'd1);
        step(); step();
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
        step();
        lu_valid = 1'b0;
        step();
        chk("raw_pop_we_lit",   64'(we),     64'd1);
        chk("raw_pop_addr_lit", 64'(wraddr), 64'd7);
        chk("raw_pop_data_lit", 64'(wrdata), 64'h1234);
        chk("raw_release_lit",  64'(stall),  64'd0);
        step();
        idle();
        step();

        // ALU holds the port for 6 cycles while 5 lu results arrive
        for (int i = 0; i < 5; i++) begin
            lrd[i]  = AW'(10 + i);
            ldat[i] = 32'hA0 + 32'(i);
        end
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'(c);
            lu_valid = (idx < 5);
            lu_rd    = lrd[idx < 5 ? idx : 4];
            lu_data  = ldat[idx < 5 ? idx : 4];
            step();
            if (mpushed) idx++;
        end
        chk("full_count_lit", 64'(q_count),  64'd4);
        chk("full_ready_lit", 64'(lu_ready), 64'd0);

        // full queue: pop with lu_valid held, push lands next cycle
        alu_valid = 1'b0;
        step();
        if (mpushed) idx++;
        chk("full_pop_count_lit", 64'(q_count), 64'd3);
        chk("full_pop_addr_lit",  64'(wraddr),  64'd10);
        step();
        if (mpushed) idx++;
        chk("late_push_lit",  64'(idx),     64'd5);
        chk("late_count_lit", 64'(q_count), 64'd3);
        chk("order_addr_lit", 64'(wraddr),  64'd11);
        lu_valid = 1'b0;
        for (int c = 0; c < 5; c++) step();

        // ALU rd=0 bubble lets the queue drain; rd=0 queue entry writes nothing
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h55;
        step();
        lu_rd = 5'd20; lu_data = 32'h77;
        step();
        lu_valid = 1'b0;
        alu_rd = 5'd0; alu_data = 32'hFFFF;
        step();
        chk("x0_pop_we_lit",    64'(we),      64'd0);
        chk("x0_pop_count_lit", 64'(q_count), 64'd1);
        step();
        chk("bubble_we_lit",   64'(we),     64'd1);
        chk("bubble_addr_lit", 64'(wraddr), 64'd20);
        chk("bubble_data_lit", 64'(wrdata), 64'h77);
        idle();
        step();

        // reset mid-operation with 3 queued and pending {2,9}
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd2;
        step();
        iss_rd = 5'd9;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        lu_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            lu_rd = AW'(2 + 7 * (c % 2)); lu_data = 32'hC0 + 32'(c);
            step();
        end
        idle();
        iss_valid = 1'b1; rs1 = 5'd2; rs2 = 5'd9; iss_rd = 5'd4;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_count_lit", 64'(q_count), 64'd0);
        chk("rst_we_lit",    64'(we),      64'd0);
        chk("rst_stall_lit", 64'(stall),   64'd0);
        step();
        idle();
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
